// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 NRZ receiver.
//   ws2812_rx_state_t : receiver state (SYNC, IDLE, HIGH, LOW)
//   WORD_BITS         : bits per GRB pixel word
//   HIGH_W            : width of the high-time counter
//   IDX_W             : width of the bit-position counter
package ws2812_pkg;

    localparam int WORD_BITS = 24;
    localparam int HIGH_W    = 8;
    localparam int IDX_W     = 5;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } ws2812_rx_state_t;

endpackage

// File: rtl/ws2812_sync.sv
// ws2812_sync: brings the asynchronous WS2812 line into the clk_in domain
// and detects edges on the synchronized sample.
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset
//   data_in  : raw serial line (asynchronous)
//   d_s      : synchronized line sample
//   rise     : d_s went 0 -> 1 this cycle
//   fall     : d_s went 1 -> 0 this cycle
module ws2812_sync (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic data_in,
    output logic d_s,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = data_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign d_s  = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812_in.sv
// ws2812_in: WS2812 (NeoPixel) NRZ receiver. Decodes bits from the width
// of each high pulse, assembles MSB-first 24-bit GRB words and detects the
// low-time reset gap that ends a frame.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   ws2812_data_in   : raw serial line (asynchronous)
//   bit_thr_in       : high time above this value decodes as 1
//   rst_cnt_in       : low-time cycle count ending a frame (0 acts as 1)
//   bit_rdy_out      : one-cycle pulse per decoded bit
//   bit_data_out     : decoded bit, valid with bit_rdy_out
//   data_rdy_out     : one-cycle pulse when a word completes
//   data_out         : last complete word, first bit in bit 23
//   frame_end_out    : one-cycle pulse when a reset gap ends a frame
//   err_out          : one-cycle pulse on a protocol error
module ws2812_in
    import ws2812_pkg::*;
#(
    parameter int LOW_W = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 ws2812_data_in,
    input  logic [7:0]           bit_thr_in,
    input  logic [LOW_W-1:0]     rst_cnt_in,
    output logic                 bit_rdy_out,
    output logic                 bit_data_out,
    output logic                 data_rdy_out,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 frame_end_out,
    output logic                 err_out
);

    logic d_s;
    logic rise;
    logic fall;

    ws2812_sync u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .data_in  (ws2812_data_in),
        .d_s      (d_s),
        .rise     (rise),
        .fall     (fall)
    );

    ws2812_rx_state_t state_q, state_d;

    logic [HIGH_W-1:0]    high_cnt_q, high_cnt_d;
    logic [LOW_W-1:0]     low_cnt_q, low_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    // Holds the 23 bits preceding the current one; the incoming bit
    // completes the word directly, so no 24th flop is needed.
    logic [WORD_BITS-2:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic                 bit_rdy_q, bit_rdy_d;
    logic                 bit_data_q, bit_data_d;
    logic                 data_rdy_q, data_rdy_d;
    logic                 frame_end_q, frame_end_d;
    logic                 err_q, err_d;

    logic [HIGH_W-1:0] high_inc;
    logic [LOW_W-1:0]  low_inc;
    logic [LOW_W-1:0]  rst_thr;
    logic              low_hit;
    logic              high_sat;
    logic              new_bit;
    logic              word_last;

    // Count values this cycle would reach. The rise cycle loads 0, so in
    // the fall cycle high_inc equals the number of high samples seen,
    // which is the quantity compared against the threshold.
    always_comb begin
        high_inc  = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + 1'b1;
        low_inc   = (low_cnt_q == '1) ? low_cnt_q : low_cnt_q + 1'b1;
        rst_thr   = (rst_cnt_in == '0) ? LOW_W'(1) : rst_cnt_in;
        low_hit   = (low_inc == rst_thr);
        high_sat  = (high_inc == '1);
        new_bit   = (high_inc > bit_thr_in);
        word_last = (bit_idx_q == IDX_W'(WORD_BITS - 1));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: begin
                if (!d_s && low_hit) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                // A falling edge wins over saturation in the same cycle.
                if (fall) begin
                    state_d = LOW;
                end else if (high_sat) begin
                    state_d = SYNC;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (low_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        bit_rdy_d   = 1'b0;
        bit_data_d  = 1'b0;
        data_rdy_d  = 1'b0;
        frame_end_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            SYNC: begin
                low_cnt_d = d_s ? '0 : low_inc;
            end
            IDLE: begin
                if (rise) begin
                    high_cnt_d = '0;
                end
            end
            HIGH: begin
                high_cnt_d = high_inc;
                if (fall) begin
                    bit_rdy_d  = 1'b1;
                    bit_data_d = new_bit;
                    shift_d    = {shift_q[WORD_BITS-3:0], new_bit};
                    low_cnt_d  = '0;
                    if (word_last) begin
                        data_d     = {shift_q, new_bit};
                        data_rdy_d = 1'b1;
                        bit_idx_d  = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else if (high_sat) begin
                    err_d     = 1'b1;
                    bit_idx_d = '0;
                end
            end
            LOW: begin
                low_cnt_d = low_inc;
                if (rise) begin
                    high_cnt_d = '0;
                end else if (low_hit) begin
                    frame_end_d = 1'b1;
                    // A gap in mid-word drops the partial word.
                    if (bit_idx_q != '0) begin
                        err_d     = 1'b1;
                        bit_idx_d = '0;
                    end
                end
            end
            default: begin
                low_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            bit_rdy_q   <= 1'b0;
            bit_data_q  <= 1'b0;
            data_rdy_q  <= 1'b0;
            frame_end_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            bit_rdy_q   <= bit_rdy_d;
            bit_data_q  <= bit_data_d;
            data_rdy_q  <= data_rdy_d;
            frame_end_q <= frame_end_d;
            err_q       <= err_d;
        end
    end

    assign bit_rdy_out   = bit_rdy_q;
    assign bit_data_out  = bit_data_q;
    assign data_rdy_out  = data_rdy_q;
    assign data_out      = data_q;
    assign frame_end_out = frame_end_q;
    assign err_out       = err_q;

endmodule

// File: doc/ws2812_in.md
# ws2812_in

Single-wire WS2812 (NeoPixel) NRZ receiver. It samples an asynchronous data line, measures each high pulse to decode bits, assembles MSB-first 24-bit GRB words, and detects the low-time reset that ends a frame. It is the receive-side counterpart of the LED-strip output path and is used to accept pixel data from an upstream controller or to loop back our own output for self-test.

## Interface
- `LOW_W`, default 16: width of the low-time counter and of the reset threshold.
- `clk_in`  input  1  system clock.
- `rst_n_in`  input  1  reset, asynchronous, active-low.
- `ws2812_data_in`  input  1  raw serial line, asynchronous to `clk_in`.
- `bit_thr_in`  input  8  decision threshold: a high time greater than this value decodes as 1.
- `rst_cnt_in`  input  LOW_W  low-time cycle count that constitutes a reset or frame end.
- `bit_rdy_out`  output  1  one-cycle pulse, one per decoded bit.
- `bit_data_out`  output  1  decoded bit value; valid while `bit_rdy_out` is high.
- `data_rdy_out`  output  1  one-cycle pulse when 24 bits have been assembled.
- `data_out`  output  24  assembled word, first-received bit in bit 23; held until the next word.
- `frame_end_out`  output  1  one-cycle pulse when a reset gap ends a frame.
- `err_out`  output  1  one-cycle pulse on a protocol error.

## Operation
- Input path: 2-FF synchronizer, then one edge-detect register. Edges are evaluated on the synchronized sample `d_s`.
- The state machine has four states: SYNC, IDLE, HIGH and LOW. Reset enters SYNC.
- SYNC
  - `low_cnt` counts consecutive low cycles.
  - Any high sample clears `low_cnt`.
  - When `low_cnt == rst_cnt_in`, go to IDLE. No `frame_end_out` is generated here.
- IDLE
  - A rising edge clears `high_cnt` and goes to HIGH.
- HIGH
  - `high_cnt` increments, saturating at 255.
  - On a falling edge: the bit is `(high_cnt > bit_thr_in)`. Pulse `bit_rdy_out`, shift the bit into the word register, increment `bit_idx`, clear `low_cnt`, and go to LOW.
  - If `high_cnt` reaches 255: pulse `err_out`, clear `bit_idx`, and go to SYNC.
- LOW
  - `low_cnt` increments, saturating.
  - On a rising edge: clear `high_cnt` and go to HIGH.
  - When `low_cnt == rst_cnt_in`: pulse `frame_end_out` and go to IDLE. If `bit_idx != 0`, also pulse `err_out` in the same cycle and drop the partial word (`bit_idx` returns to 0).
- Word assembly
  - `bit_idx` counts 0..23.
  - On the 24th bit, copy the shift register into `data_out`, pulse `data_rdy_out` in the same cycle as that bit's `bit_rdy_out`, and wrap `bit_idx` to 0.
- Arithmetic
  - `high_cnt` is 8-bit, `low_cnt` is LOW_W-bit, and both are unsigned.
  - The high-time comparison is strict greater-than.
  - `rst_cnt_in` of 0 behaves as 1.
- Threshold inputs are sampled continuously. Software changes them only while the line is idle.

## Timing
- Every output resets to 0, including `data_out`.
- All outputs are registered.
- Latency: `bit_rdy_out` is asserted in cycle N+1, where N is the cycle in which the edge-detect stage sees `d_s` fall. From the pin this is 3–4 clocks.
- `frame_end_out` is asserted N+1 cycles after the cycle in which `low_cnt` reaches the threshold.
- Pulses are exactly one cycle wide and there is no backpressure. The consumer must accept every pulse.
- Simultaneous events:
  - The 24th bit and a frame end cannot coincide, because they are triggered by different line states.
  - `err_out` together with `frame_end_out` is the only legal overlap.
- A high pulse of 1 synchronized cycle still decodes (as 0, unless `bit_thr_in == 0`).
- An asynchronous reset in the middle of a word discards all state; the receiver returns to SYNC and requires a full reset gap before decoding again.

## Structure
- Package `ws2812_pkg` holds:
  - the state enum `ws2812_rx_state_t` (SYNC, IDLE, HIGH, LOW);
  - `localparam WORD_BITS = 24`;
  - `localparam HIGH_W = 8`.
- Sub-module `ws2812_sync` contains the 2-FF synchronizer and the edge-detect register. It outputs `d_s`, `rise` and `fall`.
- The top level holds the FSM, counters, shift register and output registers.

## Test plan
Common settings: `bit_thr_in = 30`, `rst_cnt_in = 2500`; a 0 bit is 20 high / 42 low cycles, a 1 bit is 40 high / 22 low cycles.

1. After reset, hold the line low for 2500 cycles, then send 0xA5C3F0 -> 24 `bit_rdy_out` pulses with the matching bits, `data_rdy_out` once with `data_out = 0xA5C3F0`, then `frame_end_out` 2500 cycles after the last falling edge, with `err_out` staying 0.
2. Send three words back-to-back (0x000000, 0xFFFFFF, 0x123456) followed by a gap -> three `data_rdy_out` pulses in that order, then a single `frame_end_out`.
3. Send 10 bits followed by a 2500-cycle low -> `frame_end_out` and `err_out` in the same cycle, no `data_rdy_out`, and the next full word decodes correctly.
4. Hold the line high for 300 cycles -> `err_out` when `high_cnt` reaches 255, the receiver returns to SYNC, and pulses are ignored until 2500 low cycles have elapsed.
5. Send high times of 30 and 31 cycles -> bits 0 and 1 respectively (strict compare).
6. Assert `rst_n_in` after the 12th bit -> all outputs are 0 immediately, and the next word is decoded only after a fresh 2500-cycle gap.
